// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared types and constants for the serial copy link.
// Holds the TX/RX state enums, the line-level constants and the frame
// length helper. Optional feature macro: SERIAL_LINK_PARITY_EN (appends an
// even-parity bit to every frame).
package serial_link_pkg;

  // Line level between frames and the level of the start bit.
  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

`ifdef SERIAL_LINK_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LOAD,
    TX_SHIFT,
    TX_WAIT_RX
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_DATA,
    RX_PARITY,
    RX_WRITE
  } rx_state_e;

  // Bits per frame: start bit, data bits, optional parity bit.
  function automatic int unsigned frame_bits(input int unsigned data_width);
    return 1 + data_width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserialiser for one-wire frames (start bit, data LSB
// first, optional even parity). Emits a one-cycle word strobe per frame.
// Optional feature macro: SERIAL_LINK_PARITY_EN.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   en          - frames are only hunted for while high
//   rx_line     - serial input, one bit per clock
//   word_valid  - registered strobe, high for one cycle per received word
//   word_data   - received word, held until the next word
//   par_err     - parity mismatch for the word in word_data (parity builds)
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_line,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word_data
`ifdef SERIAL_LINK_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      RX_HUNT: begin
        if (en && (rx_line == START_LEVEL)) begin
          state_d = RX_DATA;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        // LSB arrives first, so shift in from the top.
        sr_d = {rx_line, sr_q[DATA_WIDTH-1:1]};
        if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef SERIAL_LINK_PARITY_EN
          state_d = RX_PARITY;
`else
          state_d = RX_WRITE;
          valid_d = 1'b1;
          data_d  = sr_d;
          perr_d  = 1'b0;
`endif
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      RX_PARITY: begin
`ifdef SERIAL_LINK_PARITY_EN
        state_d = RX_WRITE;
        valid_d = 1'b1;
        data_d  = sr_q;
        perr_d  = rx_line ^ (^sr_q);
`else
        state_d = RX_HUNT;
`endif
      end
      RX_WRITE: begin
        state_d = RX_HUNT;
      end
      default: state_d = RX_HUNT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_HUNT;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  assign word_valid = valid_q;
  assign word_data  = data_q;
`ifdef SERIAL_LINK_PARITY_EN
  assign par_err    = perr_q;
`endif

endmodule

// File: rtl/serial_copy_link.sv
// serial_copy_link: copies a ROM window to a RAM window through a one-wire
// serial link (tx_line normally looped back to rx_line).
// Optional feature macro: SERIAL_LINK_PARITY_EN (even parity per frame and
// the sticky parity_err output).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start                - transfer request, sampled only when idle
//   src_base, dst_base   - first ROM / RAM address (latched at start)
//   length               - word count, 0 means 2**ADDR_WIDTH
//   rom_addr, rom_q      - ROM read port, one cycle read latency
//   ram_we/addr/wdata    - RAM write port
//   tx_line, rx_line     - serial out / in
//   busy, done           - transfer in progress / one-cycle completion pulse
//   words_rx             - words written in the current or last transfer
//   parity_err           - sticky parity error (parity builds only)
module serial_copy_link
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  tx_line,
  input  logic                  rx_line,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_rx
`ifdef SERIAL_LINK_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned FRAME_W = frame_bits(DATA_WIDTH);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

  tx_state_e             state_q, state_d;
  logic [FRAME_W-1:0]    tx_sr_q, tx_sr_d;
  logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]      words_rx_q, words_rx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tx_line_q, tx_line_d;

  logic                  accept_c;
  logic [FRAME_W-1:0]    frame_c;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;

  assign accept_c = (state_q == TX_IDLE) && start;

  // Frame image, bit 0 goes out first.
`ifdef SERIAL_LINK_PARITY_EN
  assign frame_c = {^rom_q, rom_q, START_LEVEL};
`else
  assign frame_c = {rom_q, START_LEVEL};
`endif

  // TX FSM, serialiser and address/word counters.
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    len_d      = len_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    words_rx_d = words_rx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_line_d  = IDLE_LEVEL;

    // Each received word advances the destination pointer and count.
    if (rx_valid) begin
      ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
      words_rx_d = words_rx_q + CNT_W'(1);
    end

    case (state_q)
      TX_IDLE: begin
        if (accept_c) begin
          state_d    = TX_FETCH;
          // length 0 encodes a full 2**ADDR_WIDTH window.
          len_d      = {(length == '0), length};
          rom_addr_d = src_base;
          ram_addr_d = dst_base;
          words_rx_d = '0;
          tx_cnt_d   = '0;
          busy_d     = 1'b1;
        end
      end
      TX_FETCH: begin
        state_d = TX_LOAD;
      end
      TX_LOAD: begin
        state_d   = TX_SHIFT;
        tx_sr_d   = frame_c;
        tx_bit_d  = '0;
        tx_line_d = START_LEVEL;
      end
      TX_SHIFT: begin
        if (tx_bit_q == BIT_W'(FRAME_W - 1)) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          if (tx_cnt_d == len_q) begin
            state_d = TX_WAIT_RX;
          end else begin
            state_d    = TX_FETCH;
            rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          tx_bit_d  = tx_bit_q + BIT_W'(1);
          tx_sr_d   = tx_sr_q >> 1;
          tx_line_d = tx_sr_q[1];
        end
      end
      TX_WAIT_RX: begin
        if (rx_valid && ((words_rx_q + CNT_W'(1)) == len_q)) begin
          state_d = TX_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      tx_sr_q    <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      len_q      <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      words_rx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_line_q  <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      len_q      <= len_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      words_rx_q <= words_rx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_line_q  <= tx_line_d;
    end
  end

`ifdef SERIAL_LINK_PARITY_EN
  logic rx_par_err;
  logic parity_err_q;

  // Sticky parity flag, cleared by reset or a new transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (accept_c) begin
      parity_err_q <= 1'b0;
    end else if (rx_valid && rx_par_err) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`endif

  // RX listens only while a transfer is running.
  serial_frame_rx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .en         (busy_q),
    .rx_line    (rx_line),
    .word_valid (rx_valid),
    .word_data  (rx_data)
`ifdef SERIAL_LINK_PARITY_EN
    ,
    .par_err    (rx_par_err)
`endif
  );

  assign rom_addr  = rom_addr_q;
  assign ram_we    = rx_valid;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = rx_data;
  assign tx_line   = tx_line_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign words_rx  = words_rx_q;

endmodule
